// File: rtl/sseg_demux_capture.sv
// sseg_demux_capture
//   Recovers the four digit values shown on a multiplexed, active-low
//   7-segment display by sampling its digit-select and segment lines.
//   A capture happens once per settled dwell of {an,seg}. A legal digit
//   select with a known pattern updates that position. An illegal select
//   or an unknown pattern pulses err. A blank select (an = 1111) is ignored.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   an[3:0]      active-low digit select (asynchronous to clk)
//   seg[7:0]     active-low segments, bit7 = dp, bits6:0 = g..a (asynchronous)
//   hex0..hex3   last captured value per display position
//   digit_valid  bit N set once hexN has been captured since reset
//   frame_tick   one-cycle pulse once all four positions have been captured
//   err          one-cycle pulse on a settled illegal select or pattern
module sseg_demux_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] seg,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] digit_valid,
    output logic       frame_tick,
    output logic       err
);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_DONE} state_t;

    localparam logic [7:0] SC = 8'(SETTLE_CYCLES);

    // Returns {known, value}; the decimal point is not part of the digit.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [3:0]       an_s1_q, an_s2_q;
    logic [7:0]       seg_s1_q, seg_s2_q;
    logic [2:0]       fill_q;
    logic [11:0]      prev_q;
    logic [7:0]       cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0][3:0]  hex_q, hex_d;
    logic [3:0]       dv_q, dv_d;
    logic [3:0]       seen_q, seen_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic [11:0]      samp;
    logic             change;
    logic             capture;
    logic [4:0]       dec;
    logic             an_ok;
    logic             an_idle;
    logic [1:0]       pos;

    assign samp = {an_s2_q, seg_s2_q};

    // fill_q marks when the synchronizer and prev_q hold post-reset samples,
    // so the first value seen after reset is not treated as a fresh change.
    // That drops any dwell interrupted by reset until the inputs move again.
    assign change = fill_q[2] && (samp != prev_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_s1_q  <= '0;
            an_s2_q  <= '0;
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            fill_q   <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_WAIT;
            hex_q    <= '0;
            dv_q     <= '0;
            seen_q   <= '0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            fill_q   <= {fill_q[1:0], 1'b1};
            prev_q   <= samp;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hex_q    <= hex_d;
            dv_q     <= dv_d;
            seen_q   <= seen_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (change) begin
            cnt_d = 8'd1;
        end else if (cnt_q < SC) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // A change always wins over a capture due on the same edge. With
    // SETTLE_CYCLES = 1 the change itself completes the dwell.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (change) begin
            if (SC == 8'd1) begin
                state_d = S_DONE;
                capture = 1'b1;
            end else begin
                state_d = S_SETTLE;
            end
        end else if (state_q == S_SETTLE && cnt_d == SC) begin
            state_d = S_DONE;
            capture = 1'b1;
        end
    end

    always_comb begin
        an_ok   = 1'b1;
        an_idle = 1'b0;
        pos     = 2'd0;
        case (an_s2_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            4'b1111: an_idle = 1'b1;
            default: an_ok = 1'b0;
        endcase
    end

    assign dec = seg_decode(seg_s2_q[6:0]);

    // frame_tick follows the edge on which the mask fills; the mask clears
    // on the tick edge but still accepts a capture landing on that edge.
    always_comb begin
        hex_d  = hex_q;
        dv_d   = dv_q;
        err_d  = 1'b0;
        tick_d = (seen_q == 4'hF);
        seen_d = tick_d ? '0 : seen_q;
        if (capture && !an_idle) begin
            if (an_ok && dec[4]) begin
                hex_d[pos]  = dec[3:0];
                dv_d[pos]   = 1'b1;
                seen_d[pos] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign hex0        = hex_q[0];
    assign hex1        = hex_q[1];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[3];
    assign digit_valid = dv_q;
    assign frame_tick  = tick_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sseg_demux_capture.sv
// Testbench for sseg_demux_capture. Inputs are applied as dwells, where a
// value is held for a number of clock cycles. For each dwell the reference
// model predicts the visible events: a hex/valid update, an err pulse or a
// frame_tick pulse. The model pushes those events into a queue. A monitor
// process watches the outputs and pops one expectation per observed event.
module tb_sseg_demux_capture;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] hex0, hex1, hex2, hex3;
    logic [3:0] digit_valid;
    logic       frame_tick;
    logic       err;

    sseg_demux_capture #(.SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .digit_valid(digit_valid), .frame_tick(frame_tick), .err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 = value update, 1 = err pulse, 2 = frame_tick pulse
    typedef struct {
        int          kind;
        logic [15:0] hexs;
        logic [3:0]  dv;
    } ev_t;

    ev_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0]  m_hex[4];
    logic [3:0]  m_dv;
    logic [3:0]  m_seen;
    logic [11:0] cur_val;

    logic [6:0] pat_tab[11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h0E};
    logic [3:0] val_tab[11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                4'h6, 4'h7, 4'h8, 4'h9, 4'hF};

    function automatic logic [7:0] enc(input logic [3:0] d, input logic dp);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 0; i < 11; i++)
            if (val_tab[i] == d) r = {dp, pat_tab[i]};
        return r;
    endfunction

    function automatic logic [15:0] pack_hex();
        return {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    endfunction

    task automatic push(input int kind);
        ev_t e;
        e.kind = kind;
        e.hexs = pack_hex();
        e.dv   = m_dv;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
        m_dv   = 4'h0;
        m_seen = 4'h0;
    endtask

    // The model treats a settled dwell as one capture.
    task automatic model_capture(input logic [3:0] a, input logic [7:0] s);
        int p;
        int d;
        p = -1;
        d = -1;
        if (a == 4'hF) return;
        for (int i = 0; i < 4; i++)
            if (a == ~(4'b0001 << i)) p = i;
        for (int i = 0; i < 11; i++)
            if (s[6:0] == pat_tab[i]) d = i;
        if (p < 0 || d < 0) begin
            push(1);
            return;
        end
        if (m_hex[p] != val_tab[d] || !m_dv[p]) begin
            m_hex[p] = val_tab[d];
            m_dv[p]  = 1'b1;
            push(0);
        end
        m_seen[p] = 1'b1;
        if (m_seen == 4'hF) begin
            push(2);
            m_seen = 4'h0;
        end
    endtask

    // A new value changed before edge k and held for len edges is captured
    // only if it survives until edge k+1+SC. The next value is seen on edge
    // k+len+2, so the dwell must satisfy len >= SC.
    task automatic predict(input logic [3:0] a, input logic [7:0] s, input int len);
        if ({a, s} != cur_val) begin
            cur_val = {a, s};
            if (len >= SC) model_capture(a, s);
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int len);
        predict(a, s, len);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (len) @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic [19:0] last_obs;
    logic        was_err;
    logic        was_tick;

    task automatic check_event(input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d hex %h dv %b, expected none",
                     kind, {hex3, hex2, hex1, hex0}, digit_valid);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind ||
            (kind == 0 && (e.hexs != {hex3, hex2, hex1, hex0} || e.dv != digit_valid))) begin
            fails++;
            $display("FAIL event: got kind %0d hex %h dv %b, expected kind %0d hex %h dv %b",
                     kind, {hex3, hex2, hex1, hex0}, digit_valid, e.kind, e.hexs, e.dv);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            was_err  = 1'b0;
            was_tick = 1'b0;
        end else begin
            if (err && was_err) begin
                tests++; fails++;
                $display("FAIL err_width: got 2+ cycles, expected 1");
            end
            if (frame_tick && was_tick) begin
                tests++; fails++;
                $display("FAIL tick_width: got 2+ cycles, expected 1");
            end
            if (err) check_event(1);
            if (frame_tick) check_event(2);
            if ({hex3, hex2, hex1, hex0, digit_valid} != last_obs) check_event(0);
            was_err  = err;
            was_tick = frame_tick;
        end
        last_obs = {hex3, hex2, hex1, hex0, digit_valid};
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        an    = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h0);
        chk("rst_dv", {28'h0, digit_valid}, 32'h0);
        chk("rst_pulses", {30'h0, frame_tick, err}, 32'h0);
        reset = 1'b0;
        model_reset();
        cur_val = {4'hF, 8'hFF};
        repeat (5) @(posedge clk);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] s;
        logic [3:0] ill[5] = '{4'b1100, 4'b0000, 4'b1010, 4'b0101, 4'b0011};
        int         r;
        int         len;

        reset = 1'b1;
        an    = 4'hF;
        seg   = 8'hFF;
        do_reset();

        // Single digit, with latency and one-shot capture checked
        predict(4'b1110, 8'hA4, 10);
        @(negedge clk);
        an  = 4'b1110;
        seg = 8'hA4;
        repeat (5) @(posedge clk);
        #1 chk("lat_before", {28'h0, digit_valid}, 32'h0);
        @(posedge clk);
        #1 chk("lat_hex0", {24'h0, digit_valid, hex0}, {24'h0, 4'b0001, 4'h2});
        repeat (4) @(posedge clk);
        dwell(4'hF, 8'hFF, 6);

        // Pattern changing faster than the settle window
        for (int i = 0; i < 6; i++)
            dwell(4'b1101, (i % 2) ? 8'hF9 : 8'hA4, 2);
        dwell(4'hF, 8'hFF, 8);
        chk("glitch_hex1", {28'h0, hex1}, 32'h0);
        chk("glitch_dv", {28'h0, digit_valid}, 32'h1);

        // Illegal select, then undefined pattern
        dwell(4'b1100, 8'hC0, 8);
        dwell(4'hF, 8'hFF, 6);
        dwell(4'b0111, 8'hFF, 8);
        dwell(4'hF, 8'hFF, 6);
        chk("bad_seg_dv3", {31'h0, digit_valid[3]}, 32'h0);

        // All four positions in sequence
        dwell(4'b1110, enc(4'h7, 1'b1), 8);
        dwell(4'b1101, enc(4'h3, 1'b1), 8);
        dwell(4'b1011, enc(4'h9, 1'b1), 8);
        dwell(4'b0111, enc(4'hF, 1'b1), 8);
        dwell(4'hF, 8'hFF, 6);
        chk("seq_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'hF937);

        // Loopback of a display multiplexer showing 1,2,3,4, two scans
        do_reset();
        for (int sc = 0; sc < 2; sc++)
            for (int p = 0; p < 4; p++) begin
                a = ~(4'b0001 << p);
                dwell(a, enc(4'(p + 1), 1'b1), 16);
                dwell(4'hF, 8'hFF, 2);
            end
        dwell(4'hF, 8'hFF, 6);
        chk("scan_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h4321);
        chk("scan_dv", {28'h0, digit_valid}, 32'hF);

        // Randomized dwells
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) a = ~(4'b0001 << (r % 4));
            else if (r < 8) a = 4'hF;
            else a = ill[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) < 8)
                s = enc(val_tab[$urandom_range(0, 10)], 1'($urandom));
            else
                s = 8'($urandom);
            if ({a, s} == cur_val) s = s ^ 8'h80;
            len = int'($urandom_range(1, 10));
            dwell(a, s, len);
        end
        dwell(4'hF, 8'hFF, 10);

        // Reset in the middle of a settling dwell
        @(negedge clk);
        an  = 4'b1011;
        seg = enc(4'h5, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_dv", {28'h0, digit_valid}, 32'h0);
        reset = 1'b0;
        model_reset();
        cur_val = {4'b1011, enc(4'h5, 1'b0)};
        repeat (15) @(posedge clk);
        #1 chk("midrst_hold", {12'h0, hex3, hex2, hex1, hex0, digit_valid}, 32'h0);
        dwell(4'b1011, enc(4'h6, 1'b0), 8);
        dwell(4'hF, 8'hFF, 6);

        // Drain any remaining expectations within a fixed bound
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
